lane_spawn_scheduler: RTL and testbench

Schedules new falling targets into the three game lanes of the FlippyBit game. A programmable fall-tick divider sets the game pace, and the period shortens as the score rises. Every few ticks the scheduler picks a free lane by round-robin and issues a one-cycle spawn pulse with a pseudo-random 8-bit target value. It sits between the top-level game state machine (`enable`, `score`) and the three lane datapaths (`lane_busy`, `spawn`, `target`, `fall_tick`).

---
 rtl/lane_spawn_if.sv | 22 ++
 rtl/lane_spawn_scheduler.sv | 157 +++++++++++++++
 tb/tb_lane_spawn_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_spawn_if.sv
// Handshake bundle between the lane spawn scheduler and the game/lane logic.
// master = scheduler side, slave = game state machine and lane datapaths.
interface lane_spawn_if;
    logic        enable;
    logic [7:0]  score;
    logic [2:0]  lane_busy;
    logic [2:0]  spawn;
    logic [7:0]  target;
    logic        fall_tick;
    logic [25:0] period;
    logic [7:0]  skipped;

    modport master (
        input  enable, score, lane_busy,
        output spawn, target, fall_tick, period, skipped
    );

    modport slave (
        output enable, score, lane_busy,
        input  spawn, target, fall_tick, period, skipped
    );
endinterface

// File: rtl/lane_spawn_scheduler.sv
// Paces the three FlippyBit lanes and spawns LFSR targets into free lanes
// chosen round-robin every SPAWN_EVERY fall ticks.
module lane_spawn_scheduler #(
    parameter int unsigned TICK_BASE   = 50_000_000,
    parameter int unsigned TICK_MIN    = 12_500_000,
    parameter int unsigned TICK_STEP   = 150_000,
    parameter int unsigned SPAWN_EVERY = 4,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input logic         clock,
    input logic         reset,
    lane_spawn_if.master bus
);
    typedef enum logic [1:0] {IDLE, COUNT, ARB, SPAWN} state_t;

    localparam logic [7:0]  LFSR_INIT  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0]  SPAWN_LAST = 8'(SPAWN_EVERY - 1);
    localparam logic [25:0] BASE26     = 26'(TICK_BASE);
    localparam logic [25:0] MIN26      = 26'(TICK_MIN);
    localparam logic [35:0] BASE36     = 36'(TICK_BASE);
    localparam logic [35:0] MIN36      = 36'(TICK_MIN);
    localparam logic [35:0] STEP36     = 36'(TICK_STEP);

    state_t      state, state_nx;
    logic [25:0] divider;
    logic [25:0] period_q;
    logic [25:0] period_calc;
    logic [35:0] dec;
    logic [7:0]  tick_count;
    logic [7:0]  skipped_q;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic [1:0]  ptr;
    logic [1:0]  chosen;
    logic [1:0]  pick;
    logic [1:0]  l0, l1, l2;
    logic        found;
    logic        pend;
    logic        running;
    logic        tick;
    logic        trig;

    function automatic logic [1:0] nxt(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    // Unsigned compare before subtracting so a high score can never wrap.
    assign dec = 36'(bus.score) * STEP36;
    assign period_calc = (dec + MIN36 >= BASE36) ? MIN26
                                                 : 26'(BASE36 - dec);

    assign running   = (state != IDLE);
    assign tick      = running && (divider == period_q - 26'd1);
    assign trig      = tick && (tick_count == SPAWN_LAST);
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    assign l0 = ptr;
    assign l1 = nxt(l0);
    assign l2 = nxt(l1);

    always_comb begin
        found = 1'b1;
        pick  = l0;
        if (!bus.lane_busy[l0]) begin
            pick = l0;
        end else if (!bus.lane_busy[l1]) begin
            pick = l1;
        end else if (!bus.lane_busy[l2]) begin
            pick = l2;
        end else begin
            found = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.enable) state_nx = ARB;
            end
            COUNT: begin
                if (!bus.enable)      state_nx = IDLE;
                else if (trig || pend) state_nx = ARB;
            end
            ARB: begin
                if (!bus.enable) state_nx = IDLE;
                else if (found)  state_nx = SPAWN;
                else             state_nx = COUNT;
            end
            SPAWN: begin
                if (!bus.enable) state_nx = IDLE;
                else             state_nx = COUNT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            divider    <= '0;
            period_q   <= BASE26;
            tick_count <= '0;
            skipped_q  <= '0;
            lfsr       <= LFSR_INIT;
            ptr        <= '0;
            chosen     <= '0;
            pend       <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == IDLE || !bus.enable) begin
                divider    <= '0;
                tick_count <= '0;
            end else if (tick) begin
                divider    <= '0;
                period_q   <= period_calc;
                tick_count <= trig ? 8'd0 : tick_count + 8'd1;
            end else begin
                divider <= divider + 26'd1;
            end

            // A trigger landing in ARB/SPAWN is held until COUNT resumes.
            if (state == IDLE || !bus.enable) begin
                pend <= 1'b0;
            end else if (trig && state != COUNT) begin
                pend <= 1'b1;
            end else if (state == COUNT) begin
                pend <= 1'b0;
            end

            if (state == IDLE && bus.enable) begin
                period_q  <= period_calc;
                skipped_q <= '0;
            end

            if (state == ARB && bus.enable) begin
                if (found) begin
                    chosen <= pick;
                end else if (skipped_q != 8'hFF) begin
                    skipped_q <= skipped_q + 8'd1;
                end
            end

            if (state == SPAWN) begin
                lfsr <= lfsr_next;
                ptr  <= nxt(chosen);
            end
        end
    end

    assign bus.spawn     = (state == SPAWN) ? (3'b001 << chosen) : 3'b000;
    assign bus.target    = (state == SPAWN) ? lfsr : 8'h00;
    assign bus.fall_tick = tick;
    assign bus.period    = period_q;
    assign bus.skipped   = skipped_q;
endmodule

// File: tb/tb_lane_spawn_scheduler.sv
// Directed bench for lane_spawn_scheduler with a small pace (base 10, min 4,
// step 2, spawn every 2 ticks); cycle n is the cycle after edge n-1.
module tb_lane_spawn_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc;
    int   passed;
    int   total;

    lane_spawn_if bus();

    lane_spawn_scheduler #(
        .TICK_BASE(10),
        .TICK_MIN(4),
        .TICK_STEP(2),
        .SPAWN_EVERY(2),
        .SEED(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic start(input logic [7:0] sc, input logic [2:0] busy);
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.score = sc;
        bus.lane_busy = busy;
        step();
        step();
        reset = 1'b0;
        step();
        bus.enable = 1'b1;
        cyc = 0;
        step();
    endtask

    task automatic wait_spawn(input int limit, output int at,
                              output logic [2:0] s, output logic [7:0] t);
        at = -1;
        s = 3'b000;
        t = 8'h00;
        for (int i = 0; i < limit; i++) begin
            step();
            if (bus.spawn != 3'b000) begin
                at = cyc;
                s = bus.spawn;
                t = bus.target;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.score = 8'd0;
        bus.lane_busy = 3'b000;
        step();
        step();
        total++;
        if (bus.spawn !== 3'b000) $display("FAIL reset_spawn got %b want 000", bus.spawn);
        else passed++;
        total++;
        if (bus.target !== 8'h00) $display("FAIL reset_target got %h want 00", bus.target);
        else passed++;
        total++;
        if (bus.fall_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", bus.fall_tick);
        else passed++;
        total++;
        if (bus.period !== 26'd10) $display("FAIL reset_period got %0d want 10", bus.period);
        else passed++;
        total++;
        if (bus.skipped !== 8'd0) $display("FAIL reset_skipped got %0d want 0", bus.skipped);
        else passed++;
    endtask

    task automatic test_startup();
        start(8'd0, 3'b000);
        total++;
        if (bus.spawn !== 3'b000) $display("FAIL start_c1_spawn got %b want 000", bus.spawn);
        else passed++;
        step();
        total++;
        if (bus.spawn !== 3'b001) $display("FAIL start_c2_spawn got %b want 001", bus.spawn);
        else passed++;
        total++;
        if (bus.target !== 8'hA5) $display("FAIL start_c2_target got %h want a5", bus.target);
        else passed++;
        total++;
        if (bus.period !== 26'd10) $display("FAIL start_period got %0d want 10", bus.period);
        else passed++;
        step();
        total++;
        if (bus.spawn !== 3'b000) $display("FAIL start_c3_spawn got %b want 000", bus.spawn);
        else passed++;
        total++;
        if (bus.target !== 8'h00) $display("FAIL start_c3_target got %h want 00", bus.target);
        else passed++;
    endtask

    task automatic test_pace();
        int t1, t2, nt, sc;
        logic [2:0] sv;
        logic [7:0] tv;
        t1 = -1; t2 = -1; nt = 0; sc = -1; sv = '0; tv = '0;
        while (cyc < 22) begin
            step();
            if (bus.fall_tick) begin
                nt++;
                if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
            end
            if (bus.spawn != 3'b000 && sc < 0) begin
                sc = cyc; sv = bus.spawn; tv = bus.target;
            end
        end
        total++;
        if (t1 !== 10) $display("FAIL pace_tick1 got %0d want 10", t1);
        else passed++;
        total++;
        if (t2 !== 20) $display("FAIL pace_tick2 got %0d want 20", t2);
        else passed++;
        total++;
        if (nt !== 2) $display("FAIL pace_ticks got %0d want 2", nt);
        else passed++;
        total++;
        if (sc !== 22) $display("FAIL pace_spawn_cyc got %0d want 22", sc);
        else passed++;
        total++;
        if (sv !== 3'b010) $display("FAIL pace_spawn got %b want 010", sv);
        else passed++;
        total++;
        if (tv !== 8'h4A) $display("FAIL pace_target got %h want 4a", tv);
        else passed++;
    endtask

    task automatic test_busy_skip();
        int at;
        logic [2:0] s;
        logic [7:0] t;
        start(8'd0, 3'b010);
        wait_spawn(5, at, s, t);
        total++;
        if (s !== 3'b001 || at !== 2) $display("FAIL skip_first got %b@%0d want 001@2", s, at);
        else passed++;
        wait_spawn(40, at, s, t);
        total++;
        if (at !== 22) $display("FAIL skip_cyc got %0d want 22", at);
        else passed++;
        total++;
        if (s !== 3'b100) $display("FAIL skip_lane got %b want 100", s);
        else passed++;
        total++;
        if (t !== 8'h4A) $display("FAIL skip_target got %h want 4a", t);
        else passed++;
        bus.lane_busy = 3'b000;
        wait_spawn(40, at, s, t);
        total++;
        if (at !== 42 || s !== 3'b001) $display("FAIL skip_wrap got %b@%0d want 001@42", s, at);
        else passed++;
        total++;
        if (t !== 8'h95) $display("FAIL skip_target3 got %h want 95", t);
        else passed++;
    endtask

    task automatic test_all_busy();
        int ns;
        logic [7:0] sa, sb, sc, sd, se;
        ns = 0; sa = 'x; sb = 'x; sc = 'x; sd = 'x; se = 'x;
        start(8'd0, 3'b111);
        while (cyc < 5990) begin
            step();
            if (bus.spawn != 3'b000) ns++;
            if (cyc == 2)    sa = bus.skipped;
            if (cyc == 22)   sb = bus.skipped;
            if (cyc == 5062) sc = bus.skipped;
            if (cyc == 5082) sd = bus.skipped;
            if (cyc == 5982) se = bus.skipped;
        end
        total++;
        if (ns !== 0) $display("FAIL busy_spawns got %0d want 0", ns);
        else passed++;
        total++;
        if (sa !== 8'd1) $display("FAIL busy_skip1 got %0d want 1", sa);
        else passed++;
        total++;
        if (sb !== 8'd2) $display("FAIL busy_skip2 got %0d want 2", sb);
        else passed++;
        total++;
        if (sc !== 8'd254) $display("FAIL busy_skip254 got %0d want 254", sc);
        else passed++;
        total++;
        if (sd !== 8'd255) $display("FAIL busy_skip255 got %0d want 255", sd);
        else passed++;
        total++;
        if (se !== 8'd255) $display("FAIL busy_sat got %0d want 255", se);
        else passed++;
    endtask

    task automatic test_speed_up();
        logic [25:0] p9, p11, p15, p19;
        logic f13, f14, f18;
        start(8'd0, 3'b000);
        p9 = 'x; p11 = 'x; p15 = 'x; p19 = 'x; f13 = 'x; f14 = 'x; f18 = 'x;
        while (cyc < 19) begin
            step();
            if (cyc == 3)  bus.score = 8'd3;
            if (cyc == 9)  p9 = bus.period;
            if (cyc == 11) p11 = bus.period;
            if (cyc == 12) bus.score = 8'd200;
            if (cyc == 13) f13 = bus.fall_tick;
            if (cyc == 14) f14 = bus.fall_tick;
            if (cyc == 15) begin
                p15 = bus.period;
                bus.score = 8'd0;
            end
            if (cyc == 18) f18 = bus.fall_tick;
            if (cyc == 19) p19 = bus.period;
        end
        total++;
        if (p9 !== 26'd10) $display("FAIL speed_hold got %0d want 10", p9);
        else passed++;
        total++;
        if (p11 !== 26'd4) $display("FAIL speed_s3 got %0d want 4", p11);
        else passed++;
        total++;
        if (f13 !== 1'b0 || f14 !== 1'b1) $display("FAIL speed_tick got %b%b want 01", f13, f14);
        else passed++;
        total++;
        if (p15 !== 26'd4) $display("FAIL speed_clamp got %0d want 4", p15);
        else passed++;
        total++;
        if (f18 !== 1'b1) $display("FAIL speed_tick18 got %b want 1", f18);
        else passed++;
        total++;
        if (p19 !== 26'd10) $display("FAIL speed_back got %0d want 10", p19);
        else passed++;
    endtask

    task automatic test_abort();
        int at, ft;
        logic [7:0] tv;
        start(8'd0, 3'b000);
        bus.enable = 1'b0;
        bus.lane_busy = 3'b111;
        step();
        total++;
        if (bus.spawn !== 3'b000) $display("FAIL abort_spawn got %b want 000", bus.spawn);
        else passed++;
        total++;
        if (bus.skipped !== 8'd0) $display("FAIL abort_skip got %0d want 0", bus.skipped);
        else passed++;
        step();
        total++;
        if (bus.spawn !== 3'b000 || bus.fall_tick !== 1'b0)
            $display("FAIL abort_idle got %b/%b want 000/0", bus.spawn, bus.fall_tick);
        else passed++;
        bus.lane_busy = 3'b000;
        bus.enable = 1'b1;
        at = -1; ft = -1; tv = '0;
        while (cyc < 20) begin
            step();
            if (bus.spawn != 3'b000 && at < 0) begin
                at = cyc; tv = bus.target;
            end
            if (bus.fall_tick && ft < 0) ft = cyc;
        end
        total++;
        if (at !== 5) $display("FAIL abort_respawn got %0d want 5", at);
        else passed++;
        total++;
        if (tv !== 8'hA5) $display("FAIL abort_lfsr got %h want a5", tv);
        else passed++;
        total++;
        if (ft !== 13) $display("FAIL abort_divider got %0d want 13", ft);
        else passed++;
    endtask

    task automatic test_reset_in_spawn();
        start(8'd3, 3'b000);
        step();
        total++;
        if (bus.spawn !== 3'b001 || bus.period !== 26'd4)
            $display("FAIL rst_pre got %b/%0d want 001/4", bus.spawn, bus.period);
        else passed++;
        reset = 1'b1;
        bus.enable = 1'b0;
        step();
        total++;
        if (bus.spawn !== 3'b000 || bus.target !== 8'h00)
            $display("FAIL rst_spawn got %b/%h want 000/00", bus.spawn, bus.target);
        else passed++;
        total++;
        if (bus.period !== 26'd10) $display("FAIL rst_period got %0d want 10", bus.period);
        else passed++;
        total++;
        if (bus.fall_tick !== 1'b0 || bus.skipped !== 8'd0)
            $display("FAIL rst_misc got %b/%0d want 0/0", bus.fall_tick, bus.skipped);
        else passed++;
        reset = 1'b0;
        bus.score = 8'd0;
        step();
        bus.enable = 1'b1;
        cyc = 0;
        step();
        step();
        total++;
        if (bus.spawn !== 3'b001 || bus.target !== 8'hA5)
            $display("FAIL rst_restart got %b/%h want 001/a5", bus.spawn, bus.target);
        else passed++;
    endtask

    initial begin
        cyc = 0;
        passed = 0;
        total = 0;
        bus.enable = 1'b0;
        bus.score = 8'd0;
        bus.lane_busy = 3'b000;
        test_reset();
        test_startup();
        test_pace();
        test_busy_skip();
        test_all_busy();
        test_speed_up();
        test_abort();
        test_reset_in_spawn();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
